// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared widths, region size and FSM state encoding
package mem_access_ctrl_pkg;
  localparam int DEF_WORD_SIZE        = 16;
  localparam int DEF_MEM_ADDR_BITS    = 8;
  localparam int DEF_REG_REGION_WORDS = 16;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;
endpackage

// File: rtl/mem_region_guard.sv
// mem_region_guard: flags unprivileged accesses to the reserved register region
// Ports: i_addr (word address), i_priv (privileged access), o_fault (access rejected).
module mem_region_guard #(
  parameter int MEM_ADDR_BITS    = 8,
  parameter int REG_REGION_WORDS = 16
) (
  input  logic [MEM_ADDR_BITS-1:0] i_addr,
  input  logic                     i_priv,
  output logic                     o_fault
);
  assign o_fault = !i_priv && (int'(i_addr) < REG_REGION_WORDS);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store initiator for a 1-cycle-latency data memory
// Ports: req_* (request handshake), rsp_* (held response handshake),
// mem_* (DataMemory enables, address, write data, read data).
// Build option REG_REGION_GUARD_EN: rejects unprivileged accesses below REG_REGION_WORDS
// with rsp_fault=1 and no memory cycle; without it rsp_fault stays 0.
import mem_access_ctrl_pkg::*;
module mem_access_ctrl #(
  parameter int WORD_SIZE        = DEF_WORD_SIZE,
  parameter int MEM_ADDR_BITS    = DEF_MEM_ADDR_BITS,
  parameter int REG_REGION_WORDS = DEF_REG_REGION_WORDS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic                     req_priv,
  input  logic [MEM_ADDR_BITS-1:0] req_addr,
  input  logic [WORD_SIZE-1:0]     req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WORD_SIZE-1:0]     rsp_rdata,
  output logic                     rsp_fault,
  output logic                     mem_write_en,
  output logic                     mem_read_en,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]     mem_write_data,
  input  logic [WORD_SIZE-1:0]     mem_read_data
);
  state_t r_state;
  logic   r_write;
  logic   w_fault;
`ifdef REG_REGION_GUARD_EN
  mem_region_guard #(
    .MEM_ADDR_BITS(MEM_ADDR_BITS),
    .REG_REGION_WORDS(REG_REGION_WORDS)
  ) u_guard (
    .i_addr(req_addr),
    .i_priv(req_priv),
    .o_fault(w_fault)
  );
`else
  logic w_unused;
  assign w_unused = req_priv | (REG_REGION_WORDS == 0);
  assign w_fault  = 1'b0;
`endif
  assign req_ready = (r_state == IDLE) && !rst;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_write        <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_fault      <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_read_en    <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid && req_ready) begin
          r_write <= req_write;
          if (w_fault) begin
            r_state   <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            r_state        <= ACCESS;
            rsp_fault      <= 1'b0;
            mem_addr       <= req_addr;
            mem_write_data <= req_wdata;
            mem_write_en   <= req_write;
            mem_read_en    <= !req_write;
          end
        end
        ACCESS: begin
          mem_write_en <= 1'b0;
          mem_read_en  <= 1'b0;
          r_state      <= r_write ? RESP : CAPTURE;
          if (r_write) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        // read data is valid in the cycle after the read_en edge
        CAPTURE: begin
          rsp_rdata <= mem_read_data;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl paired with a behavioural data memory
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_priv = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic [15:0] mem [256];
  int          n_vec = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  mem_access_ctrl dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_priv(req_priv),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault),
    .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_write_data;
    if (mem_read_en) mem_read_data <= mem[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic xact(input logic w, input logic p, input logic [7:0] a, input logic [15:0] d,
                      input logic [15:0] er, input logic ef, input int el);
    int lat;
    int nw;
    int nr;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_write = w;
    req_priv  = p;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    nw = 0;
    nr = 0;
    while (!rsp_valid && lat < 10) begin
      chk("en_exclusive", mem_write_en & mem_read_en, 0);
      if (mem_write_en || mem_read_en) chk("mem_addr", mem_addr, a);
      nw += int'(mem_write_en);
      nr += int'(mem_read_en);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, el);
    chk("rsp_rdata", rsp_rdata, er);
    chk("rsp_fault", rsp_fault, ef);
    chk("wr_en_cycles", nw, (!ef && w) ? 1 : 0);
    chk("rd_en_cycles", nr, (!ef && !w) ? 1 : 0);
    @(negedge clk);
    chk("rsp_consumed", rsp_valid, 0);
  endtask
  initial begin
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_en", {mem_write_en, mem_read_en}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // reset mid-load: enables drop at once and no response follows
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h20;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midload_read_en", mem_read_en, 1);
    rst = 1'b1;
    #1;
    chk("midload_rst_read_en", mem_read_en, 0);
    chk("midload_rst_addr", mem_addr, 0);
    chk("midload_rst_req_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    xact(1, 0, 8'h20, 16'hBEEF, 16'h0000, 0, 2);
    xact(0, 0, 8'h20, 16'h0000, 16'hBEEF, 0, 3);
    xact(1, 0, 8'h40, 16'h5555, 16'h0000, 0, 2);
    // backpressure: held response while a second request is ignored
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h20;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 8'h40;
    req_wdata = 16'hDEAD;
    for (int i = 0; i < 8 && !rsp_valid; i++) @(negedge clk);
    chk("bp_rsp_valid", rsp_valid, 1);
    repeat (5) begin
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_rdata", rsp_rdata, 16'hBEEF);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_no_write", mem_write_en, 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", rsp_valid, 0);
    xact(0, 0, 8'h40, 16'h0000, 16'h5555, 0, 3);
    xact(1, 0, 8'h30, 16'h1111, 16'h0000, 0, 2);
    xact(1, 0, 8'h31, 16'h2222, 16'h0000, 0, 2);
    xact(0, 0, 8'h30, 16'h0000, 16'h1111, 0, 3);
    xact(0, 0, 8'h31, 16'h0000, 16'h2222, 0, 3);
`ifdef REG_REGION_GUARD_EN
    xact(0, 0, 8'h05, 16'h0000, 16'h0000, 1, 1);
    xact(1, 1, 8'h05, 16'h00AA, 16'h0000, 0, 2);
    xact(0, 1, 8'h05, 16'h0000, 16'h00AA, 0, 3);
    xact(1, 0, 8'h10, 16'h7777, 16'h0000, 0, 2);
    xact(0, 0, 8'h10, 16'h0000, 16'h7777, 0, 3);
`else
    xact(1, 0, 8'h05, 16'h1234, 16'h0000, 0, 2);
    xact(0, 0, 8'h05, 16'h0000, 16'h1234, 0, 3);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
